// File: rtl/radar_roi_extract_if.sv
// radar_roi_extract_if: sample stream in, windowed pixel stream out.
interface radar_roi_extract_if #(parameter int DATA_W = 16);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              data_start;
    logic              data_end;
    logic [DATA_W-1:0] pixel_out;
    logic              pixel_valid;
    logic              pixel_first;
    logic              pixel_last;
    logic              frame_done;
    logic              frame_short;
    logic              cfg_err;
    modport master (output in_valid, in_data, data_start, data_end,
                    input  pixel_out, pixel_valid, pixel_first, pixel_last, frame_done, frame_short, cfg_err);
    modport slave  (input  in_valid, in_data, data_start, data_end,
                    output pixel_out, pixel_valid, pixel_first, pixel_last, frame_done, frame_short, cfg_err);
endinterface

// File: rtl/radar_roi_extract.sv
// radar_roi_extract: forwards the samples of a raster, channel-interleaved frame
// that fall inside a latched rectangular window, one selected channel or all.
module radar_roi_extract #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 10,
    parameter int COL_W  = 10,
    parameter int CH_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROW_W-1:0] row_idx1,
    input  logic [ROW_W-1:0] row_idx2,
    input  logic [COL_W-1:0] col_idx1,
    input  logic [COL_W-1:0] col_idx2,
    input  logic [CH_W-1:0]  channel_num,
    input  logic             ch_all,
    input  logic [COL_W-1:0] num_cols,
    input  logic [CH_W:0]    num_chans,
    radar_roi_extract_if.slave io
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, SKIP = 2'd2;

    logic [1:0]       state, st;
    logic [ROW_W-1:0] r1_q, r2_q, row, r1, r2, cur_row;
    logic [COL_W-1:0] c1_q, c2_q, ncols_q, col, c1, c2, ncols, cur_col;
    logic [CH_W-1:0]  chn_q, ch, chn, cur_ch;
    logic [CH_W:0]    nch_q, nch;
    logic             all_q, all, first_seen, last_seen;
    logic             start, cfg_ok, first_eff, done_eff, in_win, fwd, is_last, fin, adv;
    logic             ch_wrap, col_wrap;

    // A data_start sample sees the fresh config and position 0 in the same cycle.
    assign start     = io.in_valid & io.data_start;
    assign cfg_ok    = row_idx1 <= row_idx2 && col_idx1 <= col_idx2 && col_idx2 < num_cols &&
                       (ch_all || {1'b0, channel_num} < num_chans);
    assign r1        = start ? row_idx1 : r1_q;
    assign r2        = start ? row_idx2 : r2_q;
    assign c1        = start ? col_idx1 : c1_q;
    assign c2        = start ? col_idx2 : c2_q;
    assign ncols     = start ? num_cols : ncols_q;
    assign chn       = start ? channel_num : chn_q;
    assign nch       = start ? num_chans : nch_q;
    assign all       = start ? ch_all : all_q;
    assign st        = start ? (cfg_ok ? RUN : SKIP) : state;
    assign cur_ch    = start ? '0 : ch;
    assign cur_col   = start ? '0 : col;
    assign cur_row   = start ? '0 : row;
    assign first_eff = start ? 1'b0 : first_seen;
    assign done_eff  = start ? 1'b0 : last_seen;
    assign in_win    = cur_row >= r1 && cur_row <= r2 && cur_col >= c1 && cur_col <= c2;
    assign fwd       = io.in_valid && st == RUN && !done_eff && in_win && (all || cur_ch == chn);
    assign is_last   = fwd && cur_row == r2 && cur_col == c2 &&
                       {1'b0, cur_ch} == (all ? nch - (CH_W+1)'(1) : {1'b0, chn});
    assign fin       = io.in_valid && io.data_end && st != IDLE;
    assign adv       = io.in_valid && st != IDLE;
    assign ch_wrap   = {1'b0, cur_ch} == nch - (CH_W+1)'(1);
    assign col_wrap  = cur_col == ncols - COL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            {r1_q, r2_q}   <= '0;
            {c1_q, c2_q}   <= '0;
            ncols_q        <= '0;
            chn_q          <= '0;
            nch_q          <= '0;
            all_q          <= 1'b0;
            {ch, col, row} <= '0;
            first_seen     <= 1'b0;
            last_seen      <= 1'b0;
            io.pixel_out   <= '0;
            io.pixel_valid <= 1'b0;
            io.pixel_first <= 1'b0;
            io.pixel_last  <= 1'b0;
            io.frame_done  <= 1'b0;
            io.frame_short <= 1'b0;
            io.cfg_err     <= 1'b0;
        end else begin
            if (start) begin
                {r1_q, r2_q, c1_q, c2_q} <= {row_idx1, row_idx2, col_idx1, col_idx2};
                {ncols_q, chn_q, nch_q, all_q} <= {num_cols, channel_num, num_chans, ch_all};
            end
            if (io.in_valid) begin
                state      <= fin ? IDLE : st;
                first_seen <= first_eff | fwd;
                last_seen  <= done_eff | is_last;
            end
            if (adv) begin
                ch  <= ch_wrap ? '0 : cur_ch + CH_W'(1);
                col <= ch_wrap ? (col_wrap ? '0 : cur_col + COL_W'(1)) : cur_col;
                row <= (ch_wrap && col_wrap && !(&cur_row)) ? cur_row + ROW_W'(1) : cur_row;
            end
            if (fwd) io.pixel_out <= io.in_data;
            io.pixel_valid <= fwd;
            io.pixel_first <= fwd && !first_eff;
            io.pixel_last  <= is_last;
            io.frame_done  <= fin;
            io.frame_short <= fin && st == RUN && !(done_eff || is_last);
            io.cfg_err     <= start && !cfg_ok;
        end
    end
endmodule
